// File: rtl/hazard_scoreboard_if.sv
// ID-stage issue bundle for the hazard scoreboard plus its stall/visibility outputs.
// The master drives the decoded ID-stage instruction; the slave is the scoreboard.
interface hazard_scoreboard_if;
  logic [4:0]  ID_Rs1_i;
  logic [4:0]  ID_Rs2_i;
  logic        ID_UseRs1_i;
  logic        ID_UseRs2_i;
  logic [4:0]  ID_Rd_i;
  logic        ID_RegWrite_i;
  logic        ID_MemRead_i;
  logic        ID_Mul_i;
  logic        ID_Valid_i;
  logic        EX_Flush_i;
  logic        stall_o;
  logic        mul_busy_o;
  logic [31:0] pending_o;

  modport master (
    output ID_Rs1_i, ID_Rs2_i, ID_UseRs1_i, ID_UseRs2_i, ID_Rd_i,
           ID_RegWrite_i, ID_MemRead_i, ID_Mul_i, ID_Valid_i, EX_Flush_i,
    input  stall_o, mul_busy_o, pending_o
  );

  modport slave (
    input  ID_Rs1_i, ID_Rs2_i, ID_UseRs1_i, ID_UseRs2_i, ID_Rd_i,
           ID_RegWrite_i, ID_MemRead_i, ID_Mul_i, ID_Valid_i, EX_Flush_i,
    output stall_o, mul_busy_o, pending_o
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Issue-side hazard scoreboard: per-register countdowns until a result becomes
// forwardable, a MUL-unit busy countdown, and the resulting ID-stage stall.
module hazard_scoreboard #(
  parameter int MUL_LAT = 4,
  parameter int CNT_W   = 3
) (
  input  logic               clk_i,
  input  logic               rst_i,
  hazard_scoreboard_if.slave bus
);

  localparam logic [CNT_W-1:0] LOAD_LOAD = CNT_W'(1);
  localparam logic [CNT_W-1:0] MUL_LOAD  = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [CNT_W-1:0] cnt      [32];
  logic [CNT_W-1:0] cnt_next [32];
  logic [CNT_W-1:0] mul_cnt;
  logic [CNT_W-1:0] mul_cnt_next;
  logic [4:0]       last_rd;
  logic             last_set;
  logic             last_mul;

  logic [CNT_W-1:0] rd_load_val;
  logic             writes_rd;
  logic             issue;
  logic             raw_hit;
  logic             struct_hit;
  logic             waw_hit;
  logic             stall;
  logic [31:0]      pending;

  // Value an issuing instruction would place in cnt[Rd]; ALU results need none.
  always_comb begin
    rd_load_val = '0;
    if (bus.ID_MemRead_i)
      rd_load_val = LOAD_LOAD;
    else if (bus.ID_Mul_i)
      rd_load_val = MUL_LOAD;
  end

  assign writes_rd = bus.ID_RegWrite_i && (bus.ID_Rd_i != 5'd0);

  always_comb begin
    pending = '0;
    for (int i = 1; i < 32; i++)
      pending[i] = (cnt[i] != '0);
  end

  always_comb begin
    raw_hit    = (bus.ID_UseRs1_i && pending[bus.ID_Rs1_i]) ||
                 (bus.ID_UseRs2_i && pending[bus.ID_Rs2_i]);
    struct_hit = bus.ID_Mul_i && (mul_cnt > CNT_ONE);
    waw_hit    = writes_rd && (cnt[bus.ID_Rd_i] > rd_load_val);
    stall      = !rst_i && bus.ID_Valid_i && (raw_hit || struct_hit || waw_hit);
    issue      = bus.ID_Valid_i && !stall;
  end

  // Priority per register: new issue, then flush clear, then saturating decrement.
  always_comb begin
    cnt_next[0] = '0;
    for (int i = 1; i < 32; i++) begin
      cnt_next[i] = cnt[i];
      if (issue && writes_rd && (bus.ID_Rd_i == 5'(i)))
        cnt_next[i] = rd_load_val;
      else if (bus.EX_Flush_i && last_set && (last_rd == 5'(i)))
        cnt_next[i] = '0;
      else if (cnt[i] != '0)
        cnt_next[i] = cnt[i] - CNT_ONE;
    end
  end

  always_comb begin
    mul_cnt_next = mul_cnt;
    if (issue && bus.ID_Mul_i)
      mul_cnt_next = MUL_LOAD;
    else if (bus.EX_Flush_i && last_mul)
      mul_cnt_next = '0;
    else if (mul_cnt != '0)
      mul_cnt_next = mul_cnt - CNT_ONE;
  end

  // last_* describe only the previous cycle's issue, which is what a flush kills.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < 32; i++)
        cnt[i] <= '0;
      mul_cnt  <= '0;
      last_rd  <= '0;
      last_set <= 1'b0;
      last_mul <= 1'b0;
    end else begin
      cnt      <= cnt_next;
      mul_cnt  <= mul_cnt_next;
      last_set <= issue && writes_rd && (rd_load_val != '0);
      last_mul <= issue && bus.ID_Mul_i;
      if (issue && writes_rd && (rd_load_val != '0))
        last_rd <= bus.ID_Rd_i;
    end
  end

  assign bus.stall_o    = stall;
  assign bus.mul_busy_o = !rst_i && (mul_cnt != '0);
  assign bus.pending_o  = rst_i ? 32'd0 : pending;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: reset, load-use, ALU chain, MUL latency,
// structural/WAW stalls, x0 handling and EX flush cancellation.
module tb_hazard_scoreboard;
  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   n;

  hazard_scoreboard_if bus ();

  hazard_scoreboard #(.MUL_LAT(4), .CNT_W(3)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic drive(input logic valid, input logic [4:0] rs1, input logic use1,
                       input logic [4:0] rs2, input logic use2, input logic [4:0] rd,
                       input logic rw, input logic mr, input logic ml);
    bus.ID_Valid_i    = valid;
    bus.ID_Rs1_i      = rs1;
    bus.ID_UseRs1_i   = use1;
    bus.ID_Rs2_i      = rs2;
    bus.ID_UseRs2_i   = use2;
    bus.ID_Rd_i       = rd;
    bus.ID_RegWrite_i = rw;
    bus.ID_MemRead_i  = mr;
    bus.ID_Mul_i      = ml;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Counts consecutive stall cycles with the current ID inputs held, bounded.
  task automatic count_stalls(output int cnt_out);
    cnt_out = 0;
    for (int k = 0; k < 10; k++) begin
      #1;
      if (!bus.stall_o) break;
      cnt_out++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (bus.stall_o !== 1'b0 || bus.mul_busy_o !== 1'b0 || bus.pending_o !== 32'd0) begin
      errors++;
      $display("[TB] FAIL reset_hold stall=%b busy=%b pending=%h expected 0/0/0",
               bus.stall_o, bus.mul_busy_o, bus.pending_o);
    end
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    drive(1'b1, 5'd8, 1'b1, 5'd0, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
    #1;
    checks++;
    if (bus.stall_o !== 1'b1 || bus.mul_busy_o !== 1'b1 || bus.pending_o !== 32'h0000_0100) begin
      errors++;
      $display("[TB] FAIL reset_premul stall=%b busy=%b pending=%h expected 1/1/00000100",
               bus.stall_o, bus.mul_busy_o, bus.pending_o);
    end
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.stall_o !== 1'b0 || bus.mul_busy_o !== 1'b0 || bus.pending_o !== 32'd0) begin
      errors++;
      $display("[TB] FAIL reset_midmul stall=%b busy=%b pending=%h expected 0/0/0",
               bus.stall_o, bus.mul_busy_o, bus.pending_o);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (bus.stall_o !== 1'b0 || bus.pending_o !== 32'd0) begin
      errors++;
      $display("[TB] FAIL reset_release stall=%b pending=%h expected 0/0",
               bus.stall_o, bus.pending_o);
    end
    @(negedge clk);
    idle();
  endtask

  task automatic test_load_use();
    @(negedge clk);
    drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
    #1;
    checks++;
    if (bus.stall_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL lw_issue stall=%b expected 0", bus.stall_o);
    end
    @(negedge clk);
    drive(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
    #1;
    checks++;
    if (bus.stall_o !== 1'b1 || bus.pending_o !== 32'h0000_0020) begin
      errors++;
      $display("[TB] FAIL loaduse_stall stall=%b pending=%h expected 1/00000020",
               bus.stall_o, bus.pending_o);
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus.stall_o !== 1'b0 || bus.pending_o !== 32'd0) begin
      errors++;
      $display("[TB] FAIL loaduse_release stall=%b pending=%h expected 0/0",
               bus.stall_o, bus.pending_o);
    end
    @(negedge clk);
    idle();
  endtask

  task automatic test_alu_chain();
    @(negedge clk);
    drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    #1;
    checks++;
    if (bus.stall_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL alu_first stall=%b expected 0", bus.stall_o);
    end
    @(negedge clk);
    drive(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
    #1;
    checks++;
    if (bus.stall_o !== 1'b0 || bus.pending_o !== 32'd0) begin
      errors++;
      $display("[TB] FAIL alu_dep stall=%b pending=%h expected 0/0", bus.stall_o, bus.pending_o);
    end
    @(negedge clk);
    idle();
  endtask

  task automatic test_mul();
    @(negedge clk);
    drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd8, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    drive(1'b1, 5'd8, 1'b1, 5'd0, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
    #1;
    checks++;
    if (bus.mul_busy_o !== 1'b1 || bus.pending_o !== 32'h0000_0100) begin
      errors++;
      $display("[TB] FAIL mul_busy busy=%b pending=%h expected 1/00000100",
               bus.mul_busy_o, bus.pending_o);
    end
    count_stalls(n);
    checks++;
    if (n !== 3) begin
      errors++;
      $display("[TB] FAIL mul_dep_stalls got %0d expected 3", n);
    end
    @(negedge clk);
    drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd10, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    drive(1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 5'd11, 1'b1, 1'b0, 1'b1);
    count_stalls(n);
    checks++;
    if (n !== 2) begin
      errors++;
      $display("[TB] FAIL mul_struct_stalls got %0d expected 2", n);
    end
    @(negedge clk);
    idle();
    #1;
    checks++;
    if (bus.mul_busy_o !== 1'b1 || bus.pending_o !== 32'h0000_0800) begin
      errors++;
      $display("[TB] FAIL mul_second_busy busy=%b pending=%h expected 1/00000800",
               bus.mul_busy_o, bus.pending_o);
    end
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (bus.mul_busy_o !== 1'b0 || bus.pending_o !== 32'd0) begin
      errors++;
      $display("[TB] FAIL mul_drain busy=%b pending=%h expected 0/0",
               bus.mul_busy_o, bus.pending_o);
    end
  endtask

  task automatic test_waw_x0();
    @(negedge clk);
    drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd8, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
    count_stalls(n);
    checks++;
    if (n !== 3) begin
      errors++;
      $display("[TB] FAIL waw_stalls got %0d expected 3", n);
    end
    @(negedge clk);
    drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd1, 1'b1, 1'b0, 1'b0);
    #1;
    checks++;
    if (bus.stall_o !== 1'b0 || bus.pending_o !== 32'd0) begin
      errors++;
      $display("[TB] FAIL x0_use stall=%b pending=%h expected 0/0", bus.stall_o, bus.pending_o);
    end
    @(negedge clk);
    idle();
  endtask

  task automatic test_flush();
    @(negedge clk);
    drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0);
    bus.EX_Flush_i = 1'b1;
    #1;
    checks++;
    if (bus.stall_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL flush_nomask stall=%b expected 1", bus.stall_o);
    end
    @(negedge clk);
    bus.EX_Flush_i = 1'b0;
    #1;
    checks++;
    if (bus.stall_o !== 1'b0 || bus.pending_o !== 32'd0) begin
      errors++;
      $display("[TB] FAIL flush_lw stall=%b pending=%h expected 0/0", bus.stall_o, bus.pending_o);
    end
    @(negedge clk);
    drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    idle();
    bus.EX_Flush_i = 1'b1;
    #1;
    checks++;
    if (bus.mul_busy_o !== 1'b1 || bus.pending_o !== 32'h0000_0100) begin
      errors++;
      $display("[TB] FAIL flush_mul_pre busy=%b pending=%h expected 1/00000100",
               bus.mul_busy_o, bus.pending_o);
    end
    @(negedge clk);
    bus.EX_Flush_i = 1'b0;
    drive(1'b1, 5'd8, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0);
    #1;
    checks++;
    if (bus.stall_o !== 1'b0 || bus.mul_busy_o !== 1'b0 || bus.pending_o !== 32'd0) begin
      errors++;
      $display("[TB] FAIL flush_mul stall=%b busy=%b pending=%h expected 0/0/0",
               bus.stall_o, bus.mul_busy_o, bus.pending_o);
    end
    @(negedge clk);
    idle();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.EX_Flush_i = 1'b0;
    idle();
    test_reset();
    test_load_use();
    test_alu_chain();
    test_mul();
    test_waw_x0();
    test_flush();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
